inf_cmd_collector: RTL and testbench

//  Front-end stage ahead of the Program controller: gathers the serial valid/D input stream
//  (action, formula, mode, date, data_no, four indices) into one packed command.

---
 rtl/inf_cmd_collector_pkg.sv | 72 +++++++
 rtl/cmd_index_buf.sv | 24 ++
 rtl/inf_cmd_collector.sv | 194 +++++++++++++++++++
 tb/tb_inf_cmd_collector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inf_cmd_collector_pkg.sv
// Shared types for the INF command collector: field types, the D union, the packed command
// and the collector state encoding.
package inf_cmd_collector_pkg;

    localparam int unsigned IDX_W = 12;
    localparam int unsigned IDX_N = 4;
    localparam int unsigned PTR_W = 2;

    typedef logic [1:0] Action;
    localparam Action Index_Check      = 2'd0;
    localparam Action Update           = 2'd1;
    localparam Action Check_Valid_Date = 2'd2;
    localparam Action Act_Rsvd         = 2'd3;

    typedef logic [2:0] Formula_Type;

    typedef logic [1:0] Mode;
    localparam Mode Insensitive = 2'b00;
    localparam Mode Normal      = 2'b01;
    localparam Mode Sensitive   = 2'b11;

    typedef struct packed {
        logic [3:0] M;
        logic [4:0] D;
    } Date;

    typedef logic [7:0]       Data_No;
    typedef logic [IDX_W-1:0] Index;

    typedef union packed {
        Action       [35:0] d_act;
        Formula_Type [23:0] d_formula;
        Mode         [35:0] d_mode;
        Date         [7:0]  d_date;
        Data_No      [8:0]  d_data_no;
        Index        [5:0]  d_index;
    } Data;

    // Byte-aligned date as carried in the outgoing command
    typedef struct packed {
        logic [7:0] month;
        logic [7:0] day;
    } Cmd_Date;

    typedef struct packed {
        Action       act;
        Formula_Type formula;
        Mode         mode;
        Cmd_Date     date;
        Data_No      data_no;
        Index        idx_a;
        Index        idx_b;
        Index        idx_c;
        Index        idx_d;
    } Cmd_Pkt;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_FORMULA = 3'd1,
        GET_MODE    = 3'd2,
        GET_DATE    = 3'd3,
        GET_DATA_NO = 3'd4,
        GET_INDEX   = 3'd5,
        HOLD        = 3'd6
    } cmd_state_type;

    function automatic Cmd_Date to_cmd_date(input Date d);
        to_cmd_date.month = 8'(d.M);
        to_cmd_date.day   = 8'(d.D);
    endfunction

endpackage

// File: rtl/cmd_index_buf.sv
// Four-entry index buffer filled in arrival order through a 2-bit write pointer.
module cmd_index_buf
    import inf_cmd_collector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  Index                  wr_data,
    output logic [PTR_W-1:0]      ptr,
    output Index [IDX_N-1:0]      entries
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr     <= '0;
            entries <= '0;
        end else if (wr_en) begin
            entries[ptr] <= wr_data;
            ptr          <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/inf_cmd_collector.sv
// Collects the serial INF field stream into one packed command with a valid/ready hand-off.
// Optional CMD_TIMEOUT_EN: drops a partial command after TIMEOUT_CYC idle cycles between fields.
module inf_cmd_collector
    import inf_cmd_collector_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sel_action_valid,
    input  logic   formula_valid,
    input  logic   mode_valid,
    input  logic   date_valid,
    input  logic   data_no_valid,
    input  logic   index_valid,
    input  Data    D,
    input  logic   cmd_ready,
    output logic   cmd_valid,
    output Cmd_Pkt cmd,
    output logic   in_busy,
    output logic   seq_err
);

    localparam logic [2:0] S_IDLE        = 3'(IDLE);
    localparam logic [2:0] S_GET_FORMULA = 3'(GET_FORMULA);
    localparam logic [2:0] S_GET_MODE    = 3'(GET_MODE);
    localparam logic [2:0] S_GET_DATE    = 3'(GET_DATE);
    localparam logic [2:0] S_GET_DATA_NO = 3'(GET_DATA_NO);
    localparam logic [2:0] S_GET_INDEX   = 3'(GET_INDEX);
    localparam logic [2:0] S_HOLD        = 3'(HOLD);

    logic [2:0]       state, nxt_state;
    logic             nxt_valid, nxt_busy, nxt_err;
    logic             ld_act, ld_formula, ld_mode, ld_date, ld_no, idx_wr, clr;
    logic             take, in_get, multi, any_v;
    logic [5:0]       vld;

    Action            act_q;
    Formula_Type      formula_q;
    Mode              mode_q;
    Cmd_Date          date_q;
    Data_No           no_q;
    logic [PTR_W-1:0] idx_cnt;
    Index [IDX_N-1:0] idx_q;

    logic unused_d;
    assign unused_d = ^D[71:12];

    assign vld    = {sel_action_valid, formula_valid, mode_valid, date_valid, data_no_valid, index_valid};
    assign any_v  = |vld;
    assign multi  = $countones(vld) > 1;
    assign in_get = (state != S_IDLE) && (state != S_HOLD);
    assign take   = ld_act | ld_formula | ld_mode | ld_date | ld_no | idx_wr;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned GAP_W = 4;
    logic [GAP_W-1:0] gap_cnt;
    logic             tmo;

    assign tmo = in_get && !take && (gap_cnt == GAP_W'(TIMEOUT_CYC - 1));

    // Idle-gap counter between fields of one command
    always_ff @(posedge clk) begin
        if (!rst_n || !in_get || take || tmo) gap_cnt <= '0;
        else                                  gap_cnt <= gap_cnt + GAP_W'(1);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        nxt_state  = state;
        nxt_valid  = cmd_valid;
        nxt_busy   = in_busy;
        nxt_err    = 1'b0;
        ld_act     = 1'b0;
        ld_formula = 1'b0;
        ld_mode    = 1'b0;
        ld_date    = 1'b0;
        ld_no      = 1'b0;
        idx_wr     = 1'b0;
        clr        = 1'b0;

        if (state == S_HOLD) begin
            nxt_err = any_v;
            if (cmd_valid && cmd_ready) begin
                nxt_state = S_IDLE;
                nxt_valid = 1'b0;
                nxt_busy  = 1'b0;
            end
        end else if (multi) begin
            nxt_err = 1'b1;
        end else if (sel_action_valid) begin
            // A new action always restarts collection; mid-command it is also an error
            clr     = 1'b1;
            nxt_err = (state != S_IDLE) || (D.d_act[0] == Act_Rsvd);
            if (D.d_act[0] == Act_Rsvd) begin
                nxt_state = S_IDLE;
            end else begin
                ld_act    = 1'b1;
                nxt_state = (D.d_act[0] == Index_Check) ? S_GET_FORMULA : S_GET_DATE;
            end
        end else begin
            case (state)
                S_GET_FORMULA: if (formula_valid) begin
                    ld_formula = 1'b1;
                    nxt_state  = S_GET_MODE;
                end
                S_GET_MODE: if (mode_valid) begin
                    ld_mode   = 1'b1;
                    nxt_state = S_GET_DATE;
                end
                S_GET_DATE: if (date_valid) begin
                    ld_date   = 1'b1;
                    nxt_state = S_GET_DATA_NO;
                end
                S_GET_DATA_NO: if (data_no_valid) begin
                    ld_no = 1'b1;
                    if (act_q == Check_Valid_Date) begin
                        nxt_state = S_HOLD;
                        nxt_valid = 1'b1;
                        nxt_busy  = 1'b1;
                    end else begin
                        nxt_state = S_GET_INDEX;
                    end
                end
                S_GET_INDEX: if (index_valid) begin
                    idx_wr = 1'b1;
                    if (idx_cnt == PTR_W'(IDX_N - 1)) begin
                        nxt_state = S_HOLD;
                        nxt_valid = 1'b1;
                        nxt_busy  = 1'b1;
                    end
                end
                default: ;
            endcase
            nxt_err = any_v && !take;
        end

`ifdef CMD_TIMEOUT_EN
        if (tmo) begin
            nxt_state = S_IDLE;
            clr       = 1'b1;
            nxt_err   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            in_busy   <= 1'b0;
            seq_err   <= 1'b0;
            act_q     <= '0;
            formula_q <= '0;
            mode_q    <= '0;
            date_q    <= '0;
            no_q      <= '0;
        end else begin
            state     <= nxt_state;
            cmd_valid <= nxt_valid;
            in_busy   <= nxt_busy;
            seq_err   <= nxt_err;
            // Clearing first keeps fields an action never sends at zero
            if (clr) begin
                act_q     <= '0;
                formula_q <= '0;
                mode_q    <= '0;
                date_q    <= '0;
                no_q      <= '0;
            end
            if (ld_act)     act_q     <= D.d_act[0];
            if (ld_formula) formula_q <= D.d_formula[0];
            if (ld_mode)    mode_q    <= D.d_mode[0];
            if (ld_date)    date_q    <= to_cmd_date(D.d_date[0]);
            if (ld_no)      no_q      <= D.d_data_no[0];
        end
    end

    cmd_index_buf u_idx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (idx_wr),
        .wr_data (D.d_index[0]),
        .ptr     (idx_cnt),
        .entries (idx_q)
    );

    assign cmd = {act_q, formula_q, mode_q, date_q, no_q, idx_q[0], idx_q[1], idx_q[2], idx_q[3]};

endmodule

// File: tb/tb_inf_cmd_collector.sv
// Scoreboard bench for inf_cmd_collector: directed commands, protocol errors, reset and timeout.
module tb_inf_cmd_collector;
    import inf_cmd_collector_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   sel_action_valid, formula_valid, mode_valid, date_valid, data_no_valid, index_valid;
    Data    D;
    logic   cmd_ready;
    logic   cmd_valid;
    Cmd_Pkt cmd;
    logic   in_busy;
    logic   seq_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int exp_err = 0;
    Cmd_Pkt exp_q[$];

    localparam logic [5:0] V_ACT  = 6'b100000;
    localparam logic [5:0] V_FORM = 6'b010000;
    localparam logic [5:0] V_MODE = 6'b001000;
    localparam logic [5:0] V_DATE = 6'b000100;
    localparam logic [5:0] V_NO   = 6'b000010;
    localparam logic [5:0] V_IDX  = 6'b000001;

    inf_cmd_collector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sel_action_valid (sel_action_valid),
        .formula_valid    (formula_valid),
        .mode_valid       (mode_valid),
        .date_valid       (date_valid),
        .data_no_valid    (data_no_valid),
        .index_valid      (index_valid),
        .D                (D),
        .cmd_ready        (cmd_ready),
        .cmd_valid        (cmd_valid),
        .cmd              (cmd),
        .in_busy          (in_busy),
        .seq_err          (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic Cmd_Pkt mk(input logic [1:0] a, input logic [2:0] f, input logic [1:0] m,
                                  input int mo, input int dy, input int no,
                                  input int ia, input int ib, input int ic, input int id);
        mk = {a, f, m, 8'(mo), 8'(dy), 8'(no), 12'(ia), 12'(ib), 12'(ic), 12'(id)};
    endfunction

    function automatic logic [71:0] dt(input int mo, input int dy);
        dt = 72'({4'(mo), 5'(dy)});
    endfunction

    task automatic send(input logic [5:0] m, input logic [71:0] v);
        {sel_action_valid, formula_valid, mode_valid, date_valid, data_no_valid, index_valid} = m;
        D = v;
        @(posedge clk);
        #1;
        {sel_action_valid, formula_valid, mode_valid, date_valid, data_no_valid, index_valid} = '0;
        D = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: counts error pulses and checks each handed-off command against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (seq_err) err_seen++;
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got %h with empty queue", cmd);
                end else begin
                    check("cmd_handoff", cmd, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Cmd_Pkt e;
        rst_n = 1'b0;
        cmd_ready = 1'b1;
        {sel_action_valid, formula_valid, mode_valid, date_valid, data_no_valid, index_valid} = '0;
        D = '0;
        idle(2);
        check("rst_cmd", cmd, 79'd0);
        check("rst_valid", 79'(cmd_valid), 79'd0);
        check("rst_busy", 79'(in_busy), 79'd0);
        check("rst_err", 79'(seq_err), 79'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: Index_Check with 2-cycle gaps
        send(V_ACT, 72'(Index_Check));      idle(2);
        send(V_FORM, 72'(3'h5));            idle(2);
        send(V_MODE, 72'(Sensitive));       idle(2);
        send(V_DATE, dt(12, 31));           idle(2);
        send(V_NO, 72'(200));               idle(2);
        send(V_IDX, 72'(1));                idle(2);
        send(V_IDX, 72'(2));                idle(2);
        send(V_IDX, 72'(3));                idle(2);
        check("t1_valid_early", 79'(cmd_valid), 79'd0);
        exp_q.push_back(mk(Index_Check, 3'h5, Sensitive, 12, 31, 200, 1, 2, 3, 4));
        send(V_IDX, 72'(4));
        check("t1_valid_latency", 79'(cmd_valid), 79'd1);
        check("t1_busy", 79'(in_busy), 79'd1);
        idle(2);
        check("t1_valid_after", 79'(cmd_valid), 79'd0);

        // 2: Check_Valid_Date held with ready low, stray valid during HOLD
        cmd_ready = 1'b0;
        e = mk(Check_Valid_Date, 3'h0, 2'b00, 2, 28, 7, 0, 0, 0, 0);
        send(V_ACT, 72'(Check_Valid_Date));
        send(V_DATE, dt(2, 28));
        send(V_NO, 72'(7));
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 79'(cmd_valid), 79'd1);
            check("t2_hold_busy", 79'(in_busy), 79'd1);
            check("t2_hold_cmd", cmd, e);
            idle(1);
        end
        send(V_DATE, dt(1, 1));
        exp_err++;
        check("t2_cmd_after_stray", cmd, e);
        exp_q.push_back(e);
        cmd_ready = 1'b1;
        idle(2);
        check("t2_valid_after", 79'(cmd_valid), 79'd0);
        check("t2_busy_after", 79'(in_busy), 79'd0);
        check("t2_err_count", 79'(err_seen), 79'(exp_err));

        // undefined action, then a field that is not expected in IDLE
        send(V_ACT, 72'(2'h3));  exp_err++;
        send(V_DATE, dt(3, 3));  exp_err++;
        idle(1);
        check("undef_act_err_count", 79'(err_seen), 79'(exp_err));
        check("undef_act_no_valid", 79'(cmd_valid), 79'd0);

        // 3: Update with an out-of-order formula
        send(V_ACT, 72'(Update));
        send(V_DATE, dt(6, 15));
        send(V_FORM, 72'(3'h3));  exp_err++;
        send(V_NO, 72'(9));
        send(V_IDX, 72'(4095));
        send(V_IDX, 72'(4095));
        send(V_IDX, 72'(4095));
        exp_q.push_back(mk(Update, 3'h0, 2'b00, 6, 15, 9, 4095, 4095, 4095, 4095));
        send(V_IDX, 72'(4095));
        idle(2);
        check("t3_err_count", 79'(err_seen), 79'(exp_err));

        // 4a: two valids in one cycle while in GET_DATE
        send(V_ACT, 72'(Index_Check));
        send(V_FORM, 72'(3'h1));
        send(V_MODE, 72'(Normal));
        send(V_DATE | V_NO, dt(9, 9));  exp_err++;
        send(V_DATE, dt(2, 3));
        send(V_NO, 72'(11));
        send(V_IDX, 72'(5));
        send(V_IDX, 72'(6));
        send(V_IDX, 72'(7));
        exp_q.push_back(mk(Index_Check, 3'h1, Normal, 2, 3, 11, 5, 6, 7, 8));
        send(V_IDX, 72'(8));
        idle(2);

        // 4b: new action in the middle of an Update
        send(V_ACT, 72'(Update));
        send(V_DATE, dt(4, 4));
        send(V_ACT, 72'(Check_Valid_Date));  exp_err++;
        send(V_DATE, dt(3, 15));
        exp_q.push_back(mk(Check_Valid_Date, 3'h0, 2'b00, 3, 15, 42, 0, 0, 0, 0));
        send(V_NO, 72'(42));
        idle(2);
        check("t4_err_count", 79'(err_seen), 79'(exp_err));

        // 5: reset while collecting indices
        send(V_ACT, 72'(Index_Check));
        send(V_FORM, 72'(3'h7));
        send(V_MODE, 72'(Insensitive));
        send(V_DATE, dt(1, 1));
        send(V_NO, 72'(1));
        send(V_IDX, 72'(100));
        send(V_IDX, 72'(200));
        rst_n = 1'b0;
        idle(1);
        check("t5_rst_cmd", cmd, 79'd0);
        check("t5_rst_valid", 79'(cmd_valid), 79'd0);
        check("t5_rst_busy", 79'(in_busy), 79'd0);
        check("t5_rst_err", 79'(seq_err), 79'd0);
        rst_n = 1'b1;
        idle(3);
        check("t5_no_valid_after_rst", 79'(cmd_valid), 79'd0);
        send(V_ACT, 72'(Index_Check));
        send(V_FORM, 72'(3'h2));
        send(V_MODE, 72'(Normal));
        send(V_DATE, dt(7, 4));
        send(V_NO, 72'(77));
        send(V_IDX, 72'(9));
        send(V_IDX, 72'(8));
        send(V_IDX, 72'(7));
        exp_q.push_back(mk(Index_Check, 3'h2, Normal, 7, 4, 77, 9, 8, 7, 6));
        send(V_IDX, 72'(6));
        idle(2);

        // 6: long stall after the date of an Update
        send(V_ACT, 72'(Update));
        send(V_DATE, dt(9, 9));
        idle(10);
`ifdef CMD_TIMEOUT_EN
        exp_err++;
        check("t6_timeout_err", 79'(err_seen), 79'(exp_err));
        send(V_ACT, 72'(Check_Valid_Date));
        send(V_DATE, dt(5, 5));
        exp_q.push_back(mk(Check_Valid_Date, 3'h0, 2'b00, 5, 5, 3, 0, 0, 0, 0));
        send(V_NO, 72'(3));
`else
        check("t6_no_timeout_err", 79'(err_seen), 79'(exp_err));
        send(V_NO, 72'(5));
        send(V_IDX, 72'(10));
        send(V_IDX, 72'(20));
        send(V_IDX, 72'(30));
        exp_q.push_back(mk(Update, 3'h0, 2'b00, 9, 9, 5, 10, 20, 30, 40));
        send(V_IDX, 72'(40));
`endif
        idle(3);
        check("final_err_count", 79'(err_seen), 79'(exp_err));
        check("final_queue_empty", 79'(exp_q.size()), 79'd0);
        check("final_valid_low", 79'(cmd_valid), 79'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
